rf_wb_scheduler: RTL and testbench
==================================

Name: rf_wb_scheduler

Overview:
- Owns the single write port of the 32x64 register file. Arbitrates between two writeback sources: the ALU pipe and the load/store unit.
- Keeps a per-register busy scoreboard. Stalls instruction issue on RAW/WAW hazards against writes that have not yet reached the register file.
- Sits between the issue stage, the execute/LSU writeback buses and the register file's write port.

Parameters:
- XLEN, 64, writeback data width.
- STARVE_LIMIT, 3, consecutive ALU-loss cycles after which the ALU gets forced priority (range 1..15).

Ports:
- i_clk  in  1  clock, all state on rising edge
- i_rst_n  in  1  asynchronous active-low reset
- i_issue_valid  in  1  issue stage presents an instruction
- i_issue_rd  in  5  destination register (0 = none)
- i_issue_rs1  in  5  source 1 (0 = none)
- i_issue_rs2  in  5  source 2 (0 = none)
- o_issue_stall  out  1  instruction must not issue this cycle
- i_alu_wb_valid  in  1  ALU writeback request
- i_alu_wb_rd  in  5  ALU writeback destination
- i_alu_wb_data  in  XLEN  ALU writeback data
- o_alu_wb_ready  out  1  ALU request accepted this cycle
- i_lsu_wb_valid  in  1  load writeback request
- i_lsu_wb_rd  in  5  load writeback destination
- i_lsu_wb_data  in  XLEN  load writeback data
- o_lsu_wb_ready  out  1  LSU request accepted this cycle
- o_rf_write  out  1  register file write enable
- o_rf_write_addr  out  5  register file write address
- o_rf_write_data  out  XLEN  register file write data
- o_busy_vec  out  32  scoreboard, bit n = write to xn outstanding
- o_idle  out  1  busy_vec==0 and o_rf_write==0

Behaviour:
- Reset (async, i_rst_n=0): busy_vec=0, starve_cnt=0, o_rf_write=0, o_rf_write_addr=0, o_rf_write_data=0. Outputs derived from these follow: o_idle=1, o_issue_stall=i_issue_valid-independent value computed from busy_vec=0, i.e. 0.
- Arbitration (combinational grant, valid/ready handshake; transfer = valid & ready):
  - Only one source: it is granted.
  - Both sources: LSU wins, unless starve_cnt >= STARVE_LIMIT, in which case ALU wins.
  - Sources hold valid and payload stable until ready.
- starve_cnt:
  - Increments, saturating at 15, when ALU valid and not granted.
  - Clears when ALU is granted or ALU valid is low.
- Write port: registered, 1-cycle latency.
  - The cycle after a grant: o_rf_write=1 with the granted rd/data.
  - Otherwise o_rf_write=0; addr/data hold their last values.
  - A grant with rd==0 is still accepted (ready=1) but produces o_rf_write=0.
- Scoreboard:
  - Set: bit rd sets on an accepted issue (i_issue_valid & ~o_issue_stall) with rd!=0.
  - Clear: bit clears on the cycle o_rf_write=1 for that address.
  - Same-cycle set and clear of the same bit: set wins. This cannot occur legally, because the stall rule blocks it.
  - Bit 0 is constant 0.
- Stall: o_issue_stall = i_issue_valid & (busy[rs1] | busy[rs2] | busy[rd]), with index 0 ignored.
  - Uses the registered busy_vec only; no same-cycle clear bypass.
  - One bubble after the write reaches the regfile is accepted; the regfile's write-to-read forwarding covers the read in that cycle.
- Writeback to a non-busy register (protocol error): still written; scoreboard unchanged.
- Reset mid-operation: pending grants and scoreboard are discarded. No write is emitted after i_rst_n rises until a new grant.

Decomposition:
- Shared package rv_core_pkg holds:
  - XLEN, REG_ADDR_W=5, NUM_REGS=32
  - WB_SRC_ALU=1'b0, WB_SRC_LSU=1'b1 (encoding of the registered winner, exposed for debug)
- One natural sub-module: rf_wb_arbiter, the 2-way priority arbiter with starvation counter.
- The scoreboard and write-port register stay in the top.

Test Plan:
- Reset, then ALU wb rd=5, data=0x1234 alone -> o_alu_wb_ready=1 same cycle; next cycle o_rf_write=1, addr=5, data=0x1234.
- Issue rd=7 accepted; next cycle issue rs1=7 -> o_issue_stall=1. LSU wb rd=7 granted -> o_rf_write one cycle later clears busy[7]. Stall drops the following cycle.
- ALU and LSU both valid continuously, STARVE_LIMIT=3 -> LSU granted 3 cycles, ALU granted 4th, sequence repeats; starve_cnt observed 0,1,2,3,0.
- Issue rd=0, rs1=0, rs2=0 with busy_vec=all-ones except bit0 -> no stall, busy_vec unchanged. Wb rd=0 -> ready=1, o_rf_write stays 0.
- WAW: busy[9]=1, issue rd=9 -> stall until the write to x9 lands; o_busy_vec[9] never sees a double-set.
- Assert i_rst_n=0 asynchronously mid-cycle with busy_vec=0x0000_00F0 and a grant pending -> outputs reset immediately; no o_rf_write after release; o_idle=1.

Source files
------------

// File: rtl/rf_wb_scheduler_pkg.sv
// Shared core constants for the writeback scheduler slice.
// Widths and writeback source encoding.
package rv_core_pkg;
    localparam int XLEN       = 64;
    localparam int REG_ADDR_W = 5;
    localparam int NUM_REGS   = 32;

    localparam logic WB_SRC_ALU = 1'b0;
    localparam logic WB_SRC_LSU = 1'b1;
endpackage

// File: rtl/rf_wb_scheduler_if.sv
// Issue, writeback and regfile write-port bundle.
// The slave side is the scheduler.
interface rf_wb_scheduler_if;
    import rv_core_pkg::*;

    logic                  i_issue_valid;
    logic [REG_ADDR_W-1:0] i_issue_rd;
    logic [REG_ADDR_W-1:0] i_issue_rs1;
    logic [REG_ADDR_W-1:0] i_issue_rs2;
    logic                  o_issue_stall;

    logic                  i_alu_wb_valid;
    logic [REG_ADDR_W-1:0] i_alu_wb_rd;
    logic [XLEN-1:0]       i_alu_wb_data;
    logic                  o_alu_wb_ready;

    logic                  i_lsu_wb_valid;
    logic [REG_ADDR_W-1:0] i_lsu_wb_rd;
    logic [XLEN-1:0]       i_lsu_wb_data;
    logic                  o_lsu_wb_ready;

    logic                  o_rf_write;
    logic [REG_ADDR_W-1:0] o_rf_write_addr;
    logic [XLEN-1:0]       o_rf_write_data;
    logic [NUM_REGS-1:0]   o_busy_vec;
    logic                  o_idle;
    logic                  o_wb_src;

    modport master (
        output i_issue_valid, i_issue_rd,
        output i_issue_rs1, i_issue_rs2,
        input  o_issue_stall,
        output i_alu_wb_valid, i_alu_wb_rd,
        output i_alu_wb_data,
        input  o_alu_wb_ready,
        output i_lsu_wb_valid, i_lsu_wb_rd,
        output i_lsu_wb_data,
        input  o_lsu_wb_ready,
        input  o_rf_write, o_rf_write_addr,
        input  o_rf_write_data,
        input  o_busy_vec, o_idle, o_wb_src
    );

    modport slave (
        input  i_issue_valid, i_issue_rd,
        input  i_issue_rs1, i_issue_rs2,
        output o_issue_stall,
        input  i_alu_wb_valid, i_alu_wb_rd,
        input  i_alu_wb_data,
        output o_alu_wb_ready,
        input  i_lsu_wb_valid, i_lsu_wb_rd,
        input  i_lsu_wb_data,
        output o_lsu_wb_ready,
        output o_rf_write, o_rf_write_addr,
        output o_rf_write_data,
        output o_busy_vec, o_idle, o_wb_src
    );
endinterface

// File: rtl/rf_wb_scheduler_arbiter.sv
// Two-way writeback arbiter: LSU first, ALU forced
// after STARVE_LIMIT consecutive losses.
module rf_wb_arbiter #(
    parameter int STARVE_LIMIT = 3
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       alu_valid,
    input  logic       lsu_valid,
    output logic       alu_gnt,
    output logic       lsu_gnt,
    output logic [3:0] starve_cnt
);
    logic force_alu;
    logic both;

    assign both      = alu_valid & lsu_valid;
    assign force_alu = starve_cnt >= 4'(STARVE_LIMIT);

    always_comb begin
        alu_gnt = 1'b0;
        lsu_gnt = 1'b0;
        unique case (1'b1)
            both & force_alu:              alu_gnt = 1'b1;
            lsu_valid & ~(both & force_alu): lsu_gnt = 1'b1;
            alu_valid & ~lsu_valid:        alu_gnt = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            starve_cnt <= '0;
        end else if (alu_valid && !alu_gnt) begin
            if (starve_cnt != 4'd15)
                starve_cnt <= starve_cnt + 4'd1;
        end else begin
            starve_cnt <= '0;
        end
    end
endmodule

// File: rtl/rf_wb_scheduler.sv
// Regfile write-port owner: arbitration, registered
// write port and per-register busy scoreboard.
module rf_wb_scheduler
    import rv_core_pkg::*;
#(
    parameter int STARVE_LIMIT = 3
) (
    input  logic               i_clk,
    input  logic               i_rst_n,
    rf_wb_scheduler_if.slave   bus
);
    logic                  alu_gnt;
    logic                  lsu_gnt;
    logic                  any_gnt;
    logic [3:0]            starve_cnt;
    logic [REG_ADDR_W-1:0] win_rd;
    logic [XLEN-1:0]       win_data;
    logic [NUM_REGS-1:0]   busy;
    logic [NUM_REGS-1:0]   busy_nxt;
    logic                  issue_fire;

    rf_wb_arbiter #(
        .STARVE_LIMIT (STARVE_LIMIT)
    ) u_arb (
        .clk        (i_clk),
        .rst_n      (i_rst_n),
        .alu_valid  (bus.i_alu_wb_valid),
        .lsu_valid  (bus.i_lsu_wb_valid),
        .alu_gnt    (alu_gnt),
        .lsu_gnt    (lsu_gnt),
        .starve_cnt (starve_cnt)
    );

    assign any_gnt  = alu_gnt | lsu_gnt;
    assign win_rd   = lsu_gnt ? bus.i_lsu_wb_rd
                              : bus.i_alu_wb_rd;
    assign win_data = lsu_gnt ? bus.i_lsu_wb_data
                              : bus.i_alu_wb_data;

    assign bus.o_alu_wb_ready = alu_gnt;
    assign bus.o_lsu_wb_ready = lsu_gnt;

    // busy[0] is held at 0, so x0 never stalls
    assign bus.o_issue_stall = bus.i_issue_valid &
        (busy[bus.i_issue_rs1] |
         busy[bus.i_issue_rs2] |
         busy[bus.i_issue_rd]);

    assign issue_fire = bus.i_issue_valid &
                        ~bus.o_issue_stall;

    always_comb begin
        busy_nxt = busy;
        if (bus.o_rf_write)
            busy_nxt[bus.o_rf_write_addr] = 1'b0;
        if (issue_fire && bus.i_issue_rd != '0)
            busy_nxt[bus.i_issue_rd] = 1'b1;
        busy_nxt[0] = 1'b0;
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            busy                <= '0;
            bus.o_rf_write      <= 1'b0;
            bus.o_rf_write_addr <= '0;
            bus.o_rf_write_data <= '0;
            bus.o_wb_src        <= WB_SRC_ALU;
        end else begin
            busy           <= busy_nxt;
            bus.o_rf_write <= any_gnt && (win_rd != '0);
            if (any_gnt && win_rd != '0) begin
                bus.o_rf_write_addr <= win_rd;
                bus.o_rf_write_data <= win_data;
            end
            if (any_gnt)
                bus.o_wb_src <= lsu_gnt ? WB_SRC_LSU
                                        : WB_SRC_ALU;
        end
    end

    assign bus.o_busy_vec = busy;
    assign bus.o_idle     = (busy == '0) &
                            ~bus.o_rf_write;
endmodule

// File: tb/tb_rf_wb_scheduler.sv
// Directed bench for rf_wb_scheduler.
// Inputs change on negedge; outputs sampled before posedge.
module tb_rf_wb_scheduler;
    import rv_core_pkg::*;

    logic clk;
    logic rst_n;
    int   checks;
    int   errors;

    rf_wb_scheduler_if bus ();

    rf_wb_scheduler #(
        .STARVE_LIMIT (3)
    ) dut (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic idle_inputs();
        bus.i_issue_valid  = 1'b0;
        bus.i_issue_rd     = '0;
        bus.i_issue_rs1    = '0;
        bus.i_issue_rs2    = '0;
        bus.i_alu_wb_valid = 1'b0;
        bus.i_alu_wb_rd    = '0;
        bus.i_alu_wb_data  = '0;
        bus.i_lsu_wb_valid = 1'b0;
        bus.i_lsu_wb_rd    = '0;
        bus.i_lsu_wb_data  = '0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        idle_inputs();
        bus.i_issue_valid = 1'b1;
        bus.i_issue_rs1   = 5'd3;
        @(negedge clk);
        #1;
        checks++;
        if (bus.o_busy_vec !== 32'h0) begin
            errors++;
            $display("FAIL rst_busy got %h exp 0",
                     bus.o_busy_vec);
        end
        checks++;
        if (bus.o_rf_write !== 1'b0 ||
            bus.o_rf_write_addr !== 5'd0 ||
            bus.o_rf_write_data !== 64'd0) begin
            errors++;
            $display("FAIL rst_wport got %b %h %h exp 0",
                     bus.o_rf_write, bus.o_rf_write_addr,
                     bus.o_rf_write_data);
        end
        checks++;
        if (bus.o_idle !== 1'b1 ||
            bus.o_issue_stall !== 1'b0) begin
            errors++;
            $display("FAIL rst_idle got %b/%b exp 1/0",
                     bus.o_idle, bus.o_issue_stall);
        end
        idle_inputs();
        @(negedge clk);
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_alu_single();
        bus.i_alu_wb_valid = 1'b1;
        bus.i_alu_wb_rd    = 5'd5;
        bus.i_alu_wb_data  = 64'h1234;
        #1;
        checks++;
        if (bus.o_alu_wb_ready !== 1'b1 ||
            bus.o_lsu_wb_ready !== 1'b0) begin
            errors++;
            $display("FAIL alu_ready got %b/%b exp 1/0",
                     bus.o_alu_wb_ready, bus.o_lsu_wb_ready);
        end
        tick();
        idle_inputs();
        checks++;
        if (bus.o_rf_write !== 1'b1 ||
            bus.o_rf_write_addr !== 5'd5 ||
            bus.o_rf_write_data !== 64'h1234 ||
            bus.o_wb_src !== WB_SRC_ALU) begin
            errors++;
            $display("FAIL alu_write got %b %h %h %b",
                     bus.o_rf_write, bus.o_rf_write_addr,
                     bus.o_rf_write_data, bus.o_wb_src);
        end
        tick();
        checks++;
        if (bus.o_rf_write !== 1'b0 ||
            bus.o_rf_write_addr !== 5'd5 ||
            bus.o_rf_write_data !== 64'h1234) begin
            errors++;
            $display("FAIL alu_hold got %b %h %h exp 0 5 1234",
                     bus.o_rf_write, bus.o_rf_write_addr,
                     bus.o_rf_write_data);
        end
    endtask

    task automatic test_raw();
        bus.i_issue_valid = 1'b1;
        bus.i_issue_rd    = 5'd7;
        #1;
        checks++;
        if (bus.o_issue_stall !== 1'b0) begin
            errors++;
            $display("FAIL raw_first got %b exp 0",
                     bus.o_issue_stall);
        end
        tick();
        bus.i_issue_rd     = 5'd0;
        bus.i_issue_rs1    = 5'd7;
        bus.i_lsu_wb_valid = 1'b1;
        bus.i_lsu_wb_rd    = 5'd7;
        bus.i_lsu_wb_data  = 64'hABCD;
        #1;
        checks++;
        if (bus.o_issue_stall !== 1'b1 ||
            bus.o_busy_vec !== 32'h80 ||
            bus.o_lsu_wb_ready !== 1'b1) begin
            errors++;
            $display("FAIL raw_stall got %b %h %b exp 1 80 1",
                     bus.o_issue_stall, bus.o_busy_vec,
                     bus.o_lsu_wb_ready);
        end
        tick();
        bus.i_lsu_wb_valid = 1'b0;
        #1;
        checks++;
        if (bus.o_rf_write !== 1'b1 ||
            bus.o_rf_write_addr !== 5'd7 ||
            bus.o_rf_write_data !== 64'hABCD ||
            bus.o_wb_src !== WB_SRC_LSU ||
            bus.o_issue_stall !== 1'b1) begin
            errors++;
            $display("FAIL raw_write got %b %h %h %b %b",
                     bus.o_rf_write, bus.o_rf_write_addr,
                     bus.o_rf_write_data, bus.o_wb_src,
                     bus.o_issue_stall);
        end
        tick();
        checks++;
        if (bus.o_issue_stall !== 1'b0 ||
            bus.o_busy_vec !== 32'h0) begin
            errors++;
            $display("FAIL raw_clear got %b %h exp 0 0",
                     bus.o_issue_stall, bus.o_busy_vec);
        end
        idle_inputs();
        tick();
    endtask

    task automatic test_starve();
        logic [4:0] last_rd;
        logic       alu_win;
        last_rd = 5'd0;
        bus.i_alu_wb_valid = 1'b1;
        bus.i_alu_wb_rd    = 5'd10;
        bus.i_alu_wb_data  = 64'hA;
        bus.i_lsu_wb_valid = 1'b1;
        bus.i_lsu_wb_rd    = 5'd11;
        bus.i_lsu_wb_data  = 64'hB;
        for (int i = 0; i < 8; i++) begin
            #1;
            alu_win = (i % 4) == 3;
            checks++;
            if (dut.u_arb.starve_cnt !== 4'(i % 4)) begin
                errors++;
                $display("FAIL starve_cnt[%0d] got %0d exp %0d",
                         i, dut.u_arb.starve_cnt, i % 4);
            end
            checks++;
            if (bus.o_alu_wb_ready !== alu_win ||
                bus.o_lsu_wb_ready !== !alu_win) begin
                errors++;
                $display("FAIL starve_gnt[%0d] got %b/%b exp %b",
                         i, bus.o_alu_wb_ready,
                         bus.o_lsu_wb_ready, alu_win);
            end
            if (i > 0) begin
                checks++;
                if (bus.o_rf_write !== 1'b1 ||
                    bus.o_rf_write_addr !== last_rd) begin
                    errors++;
                    $display("FAIL starve_wr[%0d] got %b %0d exp 1 %0d",
                             i, bus.o_rf_write,
                             bus.o_rf_write_addr, last_rd);
                end
            end
            last_rd = alu_win ? 5'd10 : 5'd11;
            tick();
        end
        idle_inputs();
        tick();
    endtask

    task automatic test_zero_and_waw();
        for (int r = 1; r < 32; r++) begin
            bus.i_issue_valid = 1'b1;
            bus.i_issue_rd    = 5'(r);
            tick();
        end
        bus.i_issue_rd = 5'd0;
        #1;
        checks++;
        if (bus.o_busy_vec !== 32'hFFFF_FFFE ||
            bus.o_issue_stall !== 1'b0) begin
            errors++;
            $display("FAIL zero_issue got %h %b exp fffffffe 0",
                     bus.o_busy_vec, bus.o_issue_stall);
        end
        bus.i_alu_wb_valid = 1'b1;
        bus.i_alu_wb_rd    = 5'd0;
        bus.i_alu_wb_data  = 64'h55;
        #1;
        checks++;
        if (bus.o_alu_wb_ready !== 1'b1) begin
            errors++;
            $display("FAIL zero_wb_ready got %b exp 1",
                     bus.o_alu_wb_ready);
        end
        tick();
        idle_inputs();
        checks++;
        if (bus.o_rf_write !== 1'b0 ||
            bus.o_busy_vec !== 32'hFFFF_FFFE) begin
            errors++;
            $display("FAIL zero_wb_write got %b %h exp 0 fffffffe",
                     bus.o_rf_write, bus.o_busy_vec);
        end
        bus.i_issue_valid = 1'b1;
        bus.i_issue_rd    = 5'd9;
        for (int c = 0; c < 3; c++) begin
            #1;
            checks++;
            if (bus.o_issue_stall !== 1'b1) begin
                errors++;
                $display("FAIL waw_stall[%0d] got %b exp 1",
                         c, bus.o_issue_stall);
            end
            tick();
        end
        bus.i_alu_wb_valid = 1'b1;
        bus.i_alu_wb_rd    = 5'd9;
        bus.i_alu_wb_data  = 64'h99;
        tick();
        bus.i_alu_wb_valid = 1'b0;
        #1;
        checks++;
        if (bus.o_rf_write !== 1'b1 ||
            bus.o_rf_write_addr !== 5'd9 ||
            bus.o_issue_stall !== 1'b1 ||
            bus.o_busy_vec[9] !== 1'b1) begin
            errors++;
            $display("FAIL waw_land got %b %0d %b %b",
                     bus.o_rf_write, bus.o_rf_write_addr,
                     bus.o_issue_stall, bus.o_busy_vec[9]);
        end
        tick();
        checks++;
        if (bus.o_issue_stall !== 1'b0 ||
            bus.o_busy_vec !== 32'hFFFF_FDFE) begin
            errors++;
            $display("FAIL waw_clear got %b %h exp 0 fffffdfe",
                     bus.o_issue_stall, bus.o_busy_vec);
        end
        tick();
        idle_inputs();
        checks++;
        if (bus.o_busy_vec !== 32'hFFFF_FFFE) begin
            errors++;
            $display("FAIL waw_reissue got %h exp fffffffe",
                     bus.o_busy_vec);
        end
    endtask

    task automatic test_reset_mid();
        rst_n = 1'b0;
        #1;
        checks++;
        if (bus.o_busy_vec !== 32'h0) begin
            errors++;
            $display("FAIL mid_pre_rst got %h exp 0",
                     bus.o_busy_vec);
        end
        @(negedge clk);
        rst_n = 1'b1;
        for (int r = 4; r < 8; r++) begin
            bus.i_issue_valid = 1'b1;
            bus.i_issue_rd    = 5'(r);
            tick();
        end
        idle_inputs();
        bus.i_lsu_wb_valid = 1'b1;
        bus.i_lsu_wb_rd    = 5'd4;
        bus.i_lsu_wb_data  = 64'h4444;
        #1;
        checks++;
        if (bus.o_busy_vec !== 32'hF0 ||
            bus.o_lsu_wb_ready !== 1'b1) begin
            errors++;
            $display("FAIL mid_setup got %h %b exp f0 1",
                     bus.o_busy_vec, bus.o_lsu_wb_ready);
        end
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (bus.o_busy_vec !== 32'h0 ||
            bus.o_rf_write !== 1'b0 ||
            bus.o_idle !== 1'b1 ||
            bus.o_rf_write_addr !== 5'd0) begin
            errors++;
            $display("FAIL mid_rst got %h %b %b %0d",
                     bus.o_busy_vec, bus.o_rf_write,
                     bus.o_idle, bus.o_rf_write_addr);
        end
        idle_inputs();
        @(negedge clk);
        rst_n = 1'b1;
        for (int c = 0; c < 3; c++) begin
            tick();
            checks++;
            if (bus.o_rf_write !== 1'b0 ||
                bus.o_idle !== 1'b1) begin
                errors++;
                $display("FAIL mid_post[%0d] got %b %b exp 0 1",
                         c, bus.o_rf_write, bus.o_idle);
            end
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_alu_single();
        test_raw();
        test_starve();
        test_zero_and_waw();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
